sum_collector: RTL and testbench
================================

// Module: sum_collector
// PURPOSE
//  Downstream stage of the 2-bit adder: captures each adder result (out_c) into a
//  small FIFO with valid/ready handshake toward the consumer. Keeps a running sum of
//  every accepted result and counts results dropped because the FIFO was full.
//  Sits between the adder and any downstream checker or logger.
// PARAMETERS
//  DATA_W  3  width of one result word (matches adder out_c)
//  DEPTH   4  FIFO entries; power of two, >= 2
//  ACC_W   8  width of the running-sum accumulator
// PORTS
//  clk       in   1                  clock, rising-edge
//  rst_n     in   1                  async active-low reset
//  in_valid  in   1                  producer has a result on in_data
//  in_data   in   DATA_W             result word from the adder
//  in_ready  out  1                  FIFO can accept this cycle
//  out_valid out  1                  head entry available
//  out_data  out  DATA_W             head entry (oldest)
//  out_ready in   1                  consumer takes head this cycle
//  count     out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  acc       out  ACC_W              running sum of accepted words
//  drop_cnt  out  8                  pushes refused while full
//  clr       in   1                  sync clear of acc and drop_cnt
// BEHAVIOUR
//  - Reset (async, rst_n=0): pointers, count, acc and drop_cnt go to 0; contents are
//    discarded. Outputs: out_valid=0, in_ready=1, count=0, acc=0, drop_cnt=0.
//    out_data is don't-care while out_valid=0. Reset asserted mid-operation aborts
//    all in-flight data with no partial pop.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH); out_valid = (count != 0). Both decode from
//    registered count only; neither depends combinationally on in_valid/out_ready.
//  - out_data = mem[rd_ptr], read combinationally from the registered pointer.
//  - Latency: a word pushed at edge N is visible on out_data/out_valid after edge N.
//    There is no empty-bypass. Push and pop while empty: only the push occurs.
//  - Full FIFO: in_ready=0, so a simultaneous pop and in_valid pops only. The freed
//    slot is offered on the next cycle.
//  - Push and pop in the same cycle with 0<count<DEPTH: count is unchanged and FIFO
//    order is preserved.
//  - wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - count += push - pop.
//  - acc: on push, acc <= acc + zero-extended in_data, modulo 2^ACC_W.
//  - drop_cnt: increments when in_valid & ~in_ready. It saturates at 255.
//  - clr=1: acc <= (push ? in_data : 0) and drop_cnt <= 0. clr takes priority over
//    increments; a drop in the same cycle is not counted. FIFO state is untouched.
//  - All state updates on the rising edge of clk. No combinational path from in_* to
//    out_*.
// CONFIGURATION
//  ACC_SATURATE_EN defined: acc saturates at {ACC_W{1'b1}} instead of wrapping, and
//    stays there until clr or reset.
//  ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W.
//  The macro has no effect on FIFO, handshake or drop_cnt.
// TESTING
//  1 rst_n=0 mid-traffic with count=3 -> out_valid=0, in_ready=1, count=0, acc=0,
//    drop_cnt=0, all immediately and without waiting for a clk edge.
//  2 out_ready=0, push 1,6,3,2 -> count=4, in_ready=0, acc=12; then out_ready=1 ->
//    out_data 1,6,3,2 on consecutive cycles, then out_valid=0.
//  3 Full FIFO, in_valid=1, in_data=5 for 3 cycles -> drop_cnt=3, acc=12, count=4.
//    Then 300 refused cycles -> drop_cnt=255.
//  4 count=2, push 4 and pop together for 6 cycles -> count stays 2, output order
//    equals input order, no word lost or duplicated.
//  5 43 pushes of 6 (total 258), popping freely -> acc=2 without ACC_SATURATE_EN,
//    acc=255 with it.
//  6 acc=20, drop_cnt=7, count=3; clr=1 with push of 4 -> acc=4, drop_cnt=0, count=4.

Source files
------------

// File: rtl/sum_collector.sv
// Result FIFO behind the 2-bit adder, with a running sum of accepted words and a refused-push counter.
// Optional feature: define ACC_SATURATE_EN to make the accumulator saturate instead of wrap.
module sum_collector #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ACC_W-1:0]         acc,
    output logic [7:0]               drop_cnt,
    input  logic                     clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        drop_q, drop_d;
    logic              push, pop, refused;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + (ACC_W+1)'(d);
`ifdef ACC_SATURATE_EN
        acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_add = sum[ACC_W-1:0];
`endif
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Handshake flags decode from registered occupancy only.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign acc       = acc_q;
    assign drop_cnt  = drop_q;

    assign push    = in_valid & in_ready;
    assign pop     = out_valid & out_ready;
    assign refused = in_valid & ~in_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        acc_d  = acc_q;
        drop_d = drop_q;
        // clr overrides both counters; a word pushed alongside clr seeds the new sum.
        if (clr) begin
            acc_d  = push ? ACC_W'(in_data) : '0;
            drop_d = '0;
        end else begin
            if (push)    acc_d  = acc_add(acc_q, in_data);
            if (refused) drop_d = sat_inc8(drop_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_sum_collector.sv
// Scoreboard bench for sum_collector: directed scenarios plus a randomized phase against a queue-based model.
module tb_sum_collector;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int ACC_W  = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid, out_ready, clr;
    logic [DATA_W-1:0]      in_data;
    logic                   in_ready, out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [$clog2(DEPTH):0] count;
    logic [ACC_W-1:0]       acc;
    logic [7:0]             drop_cnt;

    sum_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .acc(acc), .drop_cnt(drop_cnt), .clr(clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int mcount = 0;
    int macc   = 0;
    int mdrop  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must match the oldest outstanding word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pop: got %0d expected no word at %0t", out_data, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_data) != e) begin
                    n_err++;
                    $display("FAIL out_data: got %0d expected %0d at %0t", out_data, e, $time);
                end
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input bit v, input int d, input bit r, input bit c);
        bit push, pop, drop;
        in_valid  = v;
        in_data   = DATA_W'(d);
        out_ready = r;
        clr       = c;
        @(negedge clk);
        push = v && (mcount < DEPTH);
        pop  = r && (mcount > 0);
        drop = v && (mcount == DEPTH);
        if (push) exp_q.push_back(d % (1 << DATA_W));
        mcount = mcount + int'(push) - int'(pop);
        if (c) begin
            macc  = push ? d % (1 << DATA_W) : 0;
            mdrop = 0;
        end else begin
            if (push) begin
                macc = macc + d % (1 << DATA_W);
`ifdef ACC_SATURATE_EN
                if (macc > (1 << ACC_W) - 1) macc = (1 << ACC_W) - 1;
`else
                macc = macc % (1 << ACC_W);
`endif
            end
            if (drop && mdrop < 255) mdrop++;
        end
        @(posedge clk);
        #1;
        check("count", int'(count), mcount);
        check("acc", int'(acc), macc);
        check("drop_cnt", int'(drop_cnt), mdrop);
        check("in_ready", int'(in_ready), int'(mcount != DEPTH));
        check("out_valid", int'(out_valid), int'(mcount != 0));
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mcount > 0; i++) step(0, 0, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; in_data = '0;
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_acc", int'(acc), 0);
        check("rst_drop", int'(drop_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full with consumer stalled.
        step(1, 1, 0, 0); step(1, 6, 0, 0); step(1, 3, 0, 0); step(1, 2, 0, 0);
        check("fill_count", int'(count), 4);
        check("fill_in_ready", int'(in_ready), 0);
        check("fill_acc", int'(acc), 12);

        // Refused pushes while full.
        for (int i = 0; i < 3; i++) step(1, 5, 0, 0);
        check("drop3", int'(drop_cnt), 3);
        check("drop3_acc", int'(acc), 12);
        for (int i = 0; i < 300; i++) step(1, 5, 0, 0);
        check("drop_sat", int'(drop_cnt), 255);

        // Full with pop and in_valid: only the pop happens.
        step(1, 7, 1, 0);
        check("full_pop_only", int'(count), 3);
        drain();
        check("drained_valid", int'(out_valid), 0);

        // Simultaneous push/pop at count 2.
        step(1, 4, 0, 0); step(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 7), 1, 0);
        check("pp_count", int'(count), 2);

        // Accumulator overflow behaviour.
        step(0, 0, 1, 1);
        for (int i = 0; i < 43; i++) step(1, 6, 1, 0);
`ifdef ACC_SATURATE_EN
        check("acc_overflow", int'(acc), 255);
`else
        check("acc_overflow", int'(acc), 2);
`endif
        drain();

        // clr with simultaneous push.
        step(0, 0, 0, 1);
        step(1, 7, 0, 0); step(1, 7, 0, 0); step(1, 6, 0, 0); step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 3, 0, 0);
        step(0, 0, 1, 0);
        check("pre_clr_acc", int'(acc), 20);
        check("pre_clr_drop", int'(drop_cnt), 7);
        check("pre_clr_count", int'(count), 3);
        step(1, 4, 0, 1);
        check("clr_acc", int'(acc), 4);
        check("clr_drop", int'(drop_cnt), 0);
        check("clr_count", int'(count), 4);

        // Asynchronous reset mid-traffic at count 3.
        step(0, 0, 1, 0);
        check("pre_rst_count", int'(count), 3);
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #2;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_count", int'(count), 0);
        check("arst_acc", int'(acc), 0);
        check("arst_drop", int'(drop_cnt), 0);
        exp_q.delete();
        mcount = 0; macc = 0; mdrop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, $urandom_range(0, 7), ($urandom % 3) != 0,
                 ($urandom % 40) == 0);
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
